// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, funcs, state codes
// and datapath select encodings.
package mc_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    StIf   = 3'b000,
    StId   = 3'b001,
    StExe  = 3'b010,
    StMem  = 3'b011,
    StWb   = 3'b100,
    StHalt = 3'b101,
    StTrap = 3'b110
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpSlti = 6'b001010;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpBgtz = 6'b000111;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpJal  = 6'b000011;
  localparam logic [5:0] OpHalt = 6'b111111;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnJr  = 6'b001000;

  localparam logic [1:0] PcPlus4 = 2'b00;
  localparam logic [1:0] PcRel   = 2'b01;
  localparam logic [1:0] PcAbs   = 2'b10;
  localparam logic [1:0] PcRs    = 2'b11;

  localparam logic [1:0] DstRt  = 2'b00;
  localparam logic [1:0] DstRd  = 2'b01;
  localparam logic [1:0] DstR31 = 2'b10;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSll = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] TrapNone    = 2'b00;
  localparam logic [1:0] TrapIllegal = 2'b01;
  localparam logic [1:0] TrapImem    = 2'b10;
  localparam logic [1:0] TrapDmem    = 2'b11;

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational instruction decode: op/func to datapath selects, class flags and legality.
module mc_ctrl_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       legal,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] reg_dst,
  output logic       ext_sel,
  output logic       db_sel,
  output logic       reg_wsrc,
  output logic       is_jump,
  output logic       is_jal,
  output logic       is_jr,
  output logic       is_halt,
  output logic       is_branch,
  output logic       is_mem,
  output logic       is_sw
);

  always_comb begin
    legal     = 1'b1;
    alu_op    = AluAdd;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    reg_dst   = DstRt;
    ext_sel   = 1'b1;
    db_sel    = 1'b0;
    reg_wsrc  = 1'b0;
    is_jump   = 1'b0;
    is_jal    = 1'b0;
    is_jr     = 1'b0;
    is_halt   = 1'b0;
    is_branch = 1'b0;
    is_mem    = 1'b0;
    is_sw     = 1'b0;
    case (op)
      OpR: begin
        reg_dst = DstRd;
        case (func)
          FnAdd: alu_op = AluAdd;
          FnSub: alu_op = AluSub;
          FnAnd: alu_op = AluAnd;
          FnOr:  alu_op = AluOr;
          FnSll: begin
            alu_op    = AluSll;
            alu_src_a = 1'b1;
          end
          FnSlt: alu_op = AluSlt;
          FnJr:  is_jr = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OpAddi: alu_src_b = 1'b1;
      OpOri: begin
        alu_src_b = 1'b1;
        ext_sel   = 1'b0;
        alu_op    = AluOr;
      end
      OpSlti: begin
        alu_src_b = 1'b1;
        alu_op    = AluSlt;
      end
      OpLw: begin
        alu_src_b = 1'b1;
        db_sel    = 1'b1;
        is_mem    = 1'b1;
      end
      OpSw: begin
        alu_src_b = 1'b1;
        is_mem    = 1'b1;
        is_sw     = 1'b1;
      end
      // Branches compare rs against rt (or zero) through a subtract.
      OpBeq, OpBne, OpBgtz: begin
        alu_op    = AluSub;
        is_branch = 1'b1;
      end
      OpJ: is_jump = 1'b1;
      OpJal: begin
        is_jump  = 1'b1;
        is_jal   = 1'b1;
        reg_dst  = DstR31;
        reg_wsrc = 1'b1;
      end
      OpHalt: is_halt = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM with req/ack memory handshakes, HALT/TRAP handling,
// memory timeout and cycle/retired-instruction counters.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter bit          EN_TRAP     = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             sign,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             resume,
  input  logic             cnt_clr,
  output logic [2:0]       state,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_wr,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic             db_sel,
  output logic [1:0]       reg_dst,
  output logic             ext_sel,
  output logic             reg_wsrc,
  output logic [1:0]       pc_sel,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [1:0] cause_q, cause_d;
  logic [CNT_W-1:0] cycle_q, instr_q;

  logic legal, is_jump, is_jal, is_jr, is_halt, is_branch, is_mem, is_sw;
  logic taken, timeout_hit;
  logic imem_req_c, dmem_req_c, dmem_we_c, ir_write_c, pc_write_c, reg_wr_c;

  mc_ctrl_decode u_decode (
    .op        (op),
    .func      (func),
    .legal     (legal),
    .alu_op    (alu_op),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .reg_dst   (reg_dst),
    .ext_sel   (ext_sel),
    .db_sel    (db_sel),
    .reg_wsrc  (reg_wsrc),
    .is_jump   (is_jump),
    .is_jal    (is_jal),
    .is_jr     (is_jr),
    .is_halt   (is_halt),
    .is_branch (is_branch),
    .is_mem    (is_mem),
    .is_sw     (is_sw)
  );

  assign taken = ((op == OpBeq) & zero) | ((op == OpBne) & ~zero) |
                 ((op == OpBgtz) & ~sign & ~zero);
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WaitLast);

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    wait_d     = '0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ir_write_c = 1'b0;
    pc_write_c = 1'b0;
    reg_wr_c   = 1'b0;
    pc_sel     = PcPlus4;
    case (state_q)
      StIf: begin
        imem_req_c = 1'b1;
        ir_write_c = imem_ack;
        // An ack in the last allowed cycle still wins over the timeout.
        if (imem_ack) begin
          state_d = StId;
        end else if (timeout_hit) begin
          state_d = StTrap;
          cause_d = TrapImem;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StId: begin
        if (is_jump) begin
          pc_write_c = 1'b1;
          pc_sel     = PcAbs;
          reg_wr_c   = is_jal;
          state_d    = StIf;
        end else if (is_jr) begin
          pc_write_c = 1'b1;
          pc_sel     = PcRs;
          state_d    = StIf;
        end else if (is_halt) begin
          state_d = StHalt;
        end else if (!legal) begin
          if (EN_TRAP) begin
            state_d = StTrap;
            cause_d = TrapIllegal;
          end else begin
            pc_write_c = 1'b1;
            state_d    = StIf;
          end
        end else begin
          state_d = StExe;
        end
      end
      StExe: begin
        if (is_branch) begin
          pc_write_c = 1'b1;
          pc_sel     = taken ? PcRel : PcPlus4;
          state_d    = StIf;
        end else if (is_mem) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_sw;
        if (dmem_ack) begin
          pc_write_c = is_sw;
          state_d    = is_sw ? StIf : StWb;
        end else if (timeout_hit) begin
          state_d = StTrap;
          cause_d = TrapDmem;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWb: begin
        reg_wr_c   = 1'b1;
        pc_write_c = 1'b1;
        state_d    = StIf;
      end
      StHalt, StTrap: begin
        if (resume) begin
          pc_write_c = 1'b1;
          state_d    = StIf;
        end
      end
      default: state_d = StIf;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIf;
      wait_q  <= '0;
      cause_q <= TrapNone;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (cnt_clr) begin
        cycle_q <= '0;
        instr_q <= '0;
      end else begin
        if (state_q != StHalt) cycle_q <= cycle_q + CNT_W'(1);
        if (pc_write_c) instr_q <= instr_q + CNT_W'(1);
      end
    end
  end

  // Requests and write enables are forced low while reset is asserted.
  assign imem_req   = imem_req_c & nRST;
  assign dmem_req   = dmem_req_c & nRST;
  assign dmem_we    = dmem_we_c & nRST;
  assign ir_write   = ir_write_c & nRST;
  assign pc_write   = pc_write_c & nRST;
  assign reg_wr     = reg_wr_c & nRST;

  assign state      = state_q;
  assign halted     = (state_q == StHalt);
  assign trap       = (state_q == StTrap);
  assign trap_cause = cause_q;
  assign cycle_cnt  = cycle_q;
  assign instr_cnt  = instr_q;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised multicycle control unit for the MIPS-subset CPU; replaces the separate state register plus control decoder with one block. Sequences IF/ID/EXE/MEM/WB using req/ack handshakes to instruction and data memory, so memory may have variable latency. Adds HALT and TRAP states (illegal opcode, memory timeout), resume control, and cycle and retired-instruction counters. All PC and register writes are qualified on CLK rising edge; there is no negedge logic.

Parameters:
CNT_W, 32, width of cycle_cnt and instr_cnt
MEM_TIMEOUT, 16, max consecutive unacknowledged req cycles before TRAP; 0 disables the timeout
EN_TRAP, 1, 1: illegal opcode/func enters TRAP; 0: illegal is executed as a NOP (ID→IF with pc_write)

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
op  in  6  instruction opcode (IR[31:26])
func  in  6  R-format function field (IR[5:0])
zero  in  1  ALU zero flag
sign  in  1  ALU sign flag
imem_ack  in  1  instruction memory: data valid this cycle
dmem_ack  in  1  data memory: access complete this cycle
resume  in  1  leave HALT/TRAP
cnt_clr  in  1  synchronous clear of both counters
state  out  3  IF=000 ID=001 EXE=010 MEM=011 WB=100 HALT=101 TRAP=110
imem_req, dmem_req, dmem_we  out  1 each  memory requests; dmem_we=1 for SW
ir_write, pc_write, reg_wr  out  1 each  write enables
alu_src_a  out  1  1=shamt (SLL only)
alu_src_b  out  1  1=immediate (ADDI ORI SLTI LW SW)
db_sel  out  1  1=data memory (LW)
reg_dst  out  2  00=rt 01=rd 10=r31
ext_sel  out  1  0=zero-extend (ORI) 1=sign-extend
reg_wsrc  out  1  1=PC+4 (JAL)
pc_sel  out  2  00=PC+4 01=relative 10=absolute 11=rs
alu_op  out  3  ADD=000 SUB=001 AND=010 OR=011 SLL=100 SLT=101
halted, trap  out  1 each  state==HALT / state==TRAP
trap_cause  out  2  00 none, 01 illegal, 10 imem timeout, 11 dmem timeout
cycle_cnt, instr_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (async): state=IF, counters 0, trap_cause 00, wait counter 0. All outputs are combinational from state/op/func/flags, so in IF after reset imem_req=1 and all other enables=0.
- IF: imem_req=1. ir_write=imem_ack. Go to ID on ack. Ack in the first cycle means zero wait states.
- ID: J/JAL → IF with pc_write=1, pc_sel=10. JAL also sets reg_wr=1, reg_dst=10, reg_wsrc=1.
- ID: R-format func JR → IF with pc_write=1, pc_sel=11.
- ID: HALT (111111) → HALT. Illegal op/func → TRAP with cause 01 (EN_TRAP=1). Otherwise → EXE.
- EXE: BEQ/BNE/BGTZ → IF with pc_write=1. pc_sel=01 if taken (BEQ zero=1; BNE zero=0; BGTZ sign=0 and zero=0), else 00. LW/SW → MEM. Others → WB.
- MEM: dmem_req=1. dmem_we=1 for SW. SW + ack → IF with pc_write=1. LW + ack → WB. db_sel=1 for LW in all states.
- WB: reg_wr=1, pc_write=1, pc_sel=00 → IF.
- HALT: holds; resume → IF with pc_write=1 (PC+4).
- TRAP: holds; trap_cause is held until the next trap or reset. resume → IF with pc_write=1 (skips the faulting instruction).
- Timeout: the wait counter clears on entry to IF/MEM and counts req cycles without ack. The edge ending the MEM_TIMEOUT-th such cycle goes to TRAP with cause 10 (IF) or 11 (MEM). An ack in that same cycle wins over the timeout.
- Datapath selects (alu_op, alu_src_*, reg_dst, ext_sel) are driven from op/func in every state. Encodings are as listed under Ports.
- cycle_cnt increments every cycle except in HALT. instr_cnt increments on every edge with pc_write=1. Both wrap modulo 2^CNT_W. cnt_clr has priority over increment.
- Reset mid-operation: requests drop asynchronously with nRST. No write enable is asserted while nRST=0.

Decomposition:
- Shared header (extends head.v): opcode/func codes, listed by name and value:
  - R=000000, ADDI=001000, ORI=001101, SLTI=001010
  - LW=100011, SW=101011
  - BEQ=000100, BNE=000101, BGTZ=000111
  - J=000010, JAL=000011, HALT=111111
  - funcs: ADD=100000, SUB=100010, AND=100100, OR=100101, SLL=000000, SLT=101010, JR=001000
- Also in the shared header: state codes, pc_sel/reg_dst/alu_op encodings, trap causes.
- One sub-module, mc_ctrl_decode: purely combinational op/func → datapath selects and legal flag. The FSM, wait counter and perf counters stay in mc_ctrl_fsm.

Test Plan:
- ADD (op 0, func 100000), imem_ack and dmem_ack tied 1 → states IF,ID,EXE,WB,IF. reg_wr and pc_write high only in WB. alu_op=000. instr_cnt=1, cycle_cnt=4.
- LW with dmem_ack delayed 3 cycles → MEM held 4 cycles with dmem_req=1 and dmem_we=0, then WB with db_sel=1 and reg_dst=00. Total 8 cycles.
- BNE with zero=0, then with zero=1 → pc_write in EXE with pc_sel=01, then 00. No reg_wr either time.
- JAL → ID cycle has reg_wr=1, reg_dst=10, reg_wsrc=1, pc_sel=10, pc_write=1. Next state IF.
- MEM_TIMEOUT=4, SW with no dmem_ack → TRAP after 4 MEM cycles, trap_cause=11. resume=1 → IF with pc_write=1.
- Illegal op 010011 → TRAP, cause 01. HALT op → halted=1 and cycle_cnt frozen. cnt_clr → counters 0. nRST pulsed mid-MEM → state=IF and dmem_req=0 immediately.
